dma_io_burst_ctrl: RTL and testbench

- I/O-side feeder for the DMA datapath; sits directly upstream of the DMA mux/arbiter stage.
- Accepts 32-bit words from a peripheral over valid/ready and buffers them in a small FIFO.
- Once a burst's worth of words is queued, requests the memory bus, waits for grant, then drives incrementing address, data and a write strobe, one word per cycle.
- Releases the bus after the burst and pulses done.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_sync_fifo.sv | 66 ++++++
 rtl/dma_io_burst_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dma_io_burst_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA I/O burst feeder.
// Holds the controller state enum, default widths and the word address stride.
package dma_pkg;

  localparam int DMA_DATA_W      = 32;
  localparam int DMA_ADDR_W      = 32;
  localparam int DMA_FIFO_DEPTH  = 8;
  localparam int DMA_LEN_W       = 4;
  localparam int DMA_GNT_TIMEOUT = 64;

  // Byte stride between consecutive 32-bit words on the memory bus
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    REL,
    BACKOFF
  } dma_state_t;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with show-ahead head word and occupancy count.
// Push when full and pop when empty are ignored.
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int DEPTH  = DMA_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              push_ok, pop_ok;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset; the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/dma_io_burst_ctrl.sv
// I/O-side DMA feeder: buffers peripheral words, then writes them as a granted burst.
// Optional macro DMA_GNT_TIMEOUT_EN adds grant timeout with one-cycle request backoff.
module dma_io_burst_ctrl
  import dma_pkg::*;
#(
  parameter int DATA_W      = DMA_DATA_W,
  parameter int ADDR_W      = DMA_ADDR_W,
  parameter int FIFO_DEPTH  = DMA_FIFO_DEPTH,
  parameter int LEN_W       = DMA_LEN_W,
  parameter int GNT_TIMEOUT = DMA_GNT_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          io_valid,
  input  logic [DATA_W-1:0]             io_data,
  output logic                          io_ready,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [LEN_W-1:0]              burst_len,
  output logic                          bus_req,
  input  logic                          bus_gnt,
  output logic [ADDR_W-1:0]             dma_addr,
  output logic [DATA_W-1:0]             dma_data,
  output logic                          dma_mem_wr,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef DMA_GNT_TIMEOUT_EN
  ,
  output logic                          gnt_timeout
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (2 ** LEN_W) - 1 < FIFO_DEPTH || GNT_TIMEOUT < 1) begin : g_param_check
    $error("dma_io_burst_ctrl: unsupported parameter combination");
  end

  dma_state_t        state_reg, state_next;
  logic [CW-1:0]     rem_reg, rem_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic              wr_reg, wr_next;
  logic [ADDR_W-1:0] dma_addr_reg, dma_addr_next;
  logic [DATA_W-1:0] dma_data_reg, dma_data_next;
  logic [CW-1:0]     eff_len;
  logic              issue;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;

`ifdef DMA_GNT_TIMEOUT_EN
  localparam int TW = $clog2(GNT_TIMEOUT + 1);
  logic [TW-1:0] tmo_reg, tmo_next;
`endif

  dma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (io_valid),
    .push_data (io_data),
    .pop       (issue),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign io_ready   = !fifo_full;
  assign bus_req    = (state_reg == REQ) || (state_reg == XFER);
  assign done       = (state_reg == REL);
  assign dma_mem_wr = wr_reg;
  assign dma_addr   = dma_addr_reg;
  assign dma_data   = dma_data_reg;
`ifdef DMA_GNT_TIMEOUT_EN
  assign gnt_timeout = (state_reg == BACKOFF);
`endif

  // Zero-length requests become one word; anything beyond the buffer is clamped
  always_comb begin
    if (burst_len == '0)
      eff_len = CW'(1);
    else if (int'(burst_len) > FIFO_DEPTH)
      eff_len = CW'(FIFO_DEPTH);
    else
      eff_len = CW'(burst_len);
  end

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    ptr_next      = ptr_reg;
    wr_next       = 1'b0;
    dma_addr_next = '0;
    dma_data_next = '0;
    issue         = 1'b0;
`ifdef DMA_GNT_TIMEOUT_EN
    tmo_next      = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (fifo_count >= eff_len) begin
          rem_next   = eff_len;
          ptr_next   = base_addr;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus_gnt && !fifo_empty) begin
          issue      = 1'b1;
          state_next = XFER;
        end
`ifdef DMA_GNT_TIMEOUT_EN
        else if (tmo_reg == TW'(GNT_TIMEOUT - 1))
          state_next = BACKOFF;
        else
          tmo_next = tmo_reg + TW'(1);
`endif
      end
      // rem_reg counts words not yet issued; zero means the last write is on the bus
      XFER: begin
        if (rem_reg == '0)
          state_next = REL;
        else if (bus_gnt && !fifo_empty)
          issue = 1'b1;
      end
      REL:     state_next = IDLE;
      BACKOFF: state_next = REQ;
      default: state_next = IDLE;
    endcase

    if (issue) begin
      wr_next       = 1'b1;
      dma_addr_next = ptr_reg;
      dma_data_next = fifo_head;
      ptr_next      = ptr_reg + ADDR_W'(WORD_BYTES);
      rem_next      = rem_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      ptr_reg      <= '0;
      wr_reg       <= 1'b0;
      dma_addr_reg <= '0;
      dma_data_reg <= '0;
`ifdef DMA_GNT_TIMEOUT_EN
      tmo_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      ptr_reg      <= ptr_next;
      wr_reg       <= wr_next;
      dma_addr_reg <= dma_addr_next;
      dma_data_reg <= dma_data_next;
`ifdef DMA_GNT_TIMEOUT_EN
      tmo_reg      <= tmo_next;
`endif
    end
  end

endmodule

// File: tb/tb_dma_io_burst_ctrl.sv
// Bench for dma_io_burst_ctrl: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_dma_io_burst_ctrl;

  localparam int DEPTH = 8;
`ifdef DMA_GNT_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_valid = 1'b0;
  logic [31:0] io_data = '0;
  logic        io_ready;
  logic [31:0] base_addr = '0;
  logic [3:0]  burst_len = '0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] dma_addr;
  logic [31:0] dma_data;
  logic        dma_mem_wr;
  logic        done;
  logic [3:0]  fifo_count;
`ifdef DMA_GNT_TIMEOUT_EN
  logic        gnt_timeout;
`endif

  always #5 clk = ~clk;

  dma_io_burst_ctrl #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .FIFO_DEPTH  (DEPTH),
    .LEN_W       (4),
    .GNT_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_valid   (io_valid),
    .io_data    (io_data),
    .io_ready   (io_ready),
    .base_addr  (base_addr),
    .burst_len  (burst_len),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .dma_addr   (dma_addr),
    .dma_data   (dma_data),
    .dma_mem_wr (dma_mem_wr),
    .done       (done),
    .fifo_count (fifo_count)
`ifdef DMA_GNT_TIMEOUT_EN
    ,
    .gnt_timeout(gnt_timeout)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_QUIET = 0, M_BUS = 1, M_DONE = 2, M_BACK = 3;
  logic [31:0] q[$];
  int          m_phase = M_QUIET;
  int          m_left = 0;
  logic [31:0] m_addr = '0;
  bit          m_granted = 1'b0;
  int          m_tmo = 0;
  bit          exp_wr = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;

  function automatic int eff(input int bl);
    if (bl == 0) return 1;
    if (bl > DEPTH) return DEPTH;
    return bl;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_phase = M_QUIET; m_left = 0; m_addr = '0; m_granted = 1'b0; m_tmo = 0;
      exp_wr = 1'b0; exp_addr = '0; exp_data = '0;
    end else begin
      int  n;
      bit  push_ok;
      n = q.size();
      push_ok = io_valid && (n < DEPTH);
      exp_wr = 1'b0; exp_addr = '0; exp_data = '0;
      if (m_phase == M_DONE) m_phase = M_QUIET;
      else if (m_phase == M_BACK) m_phase = M_BUS;
      else if (m_phase == M_BUS && m_left == 0) m_phase = M_DONE;
      else if (m_phase == M_BUS && bus_gnt) begin
        exp_wr = 1'b1;
        exp_addr = m_addr;
        exp_data = q.pop_front();
        m_addr = m_addr + 32'd4;
        m_left--;
        m_granted = 1'b1;
        m_tmo = 0;
      end else if (m_phase == M_BUS) begin
`ifdef DMA_GNT_TIMEOUT_EN
        if (!m_granted) begin
          m_tmo++;
          if (m_tmo == TMO) begin m_phase = M_BACK; m_tmo = 0; end
        end
`endif
      end else if (m_phase == M_QUIET && n >= eff(int'(burst_len))) begin
        m_phase = M_BUS;
        m_left = eff(int'(burst_len));
        m_addr = base_addr;
        m_granted = 1'b0;
        m_tmo = 0;
      end
      if (push_ok) q.push_back(io_data);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("bus_req",    32'(bus_req),    32'(m_phase == M_BUS));
    check("dma_mem_wr", 32'(dma_mem_wr), 32'(exp_wr));
    check("dma_addr",   dma_addr,        exp_addr);
    check("dma_data",   dma_data,        exp_data);
    check("done",       32'(done),       32'(m_phase == M_DONE));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("io_ready",   32'(io_ready),   32'(q.size() != DEPTH));
`ifdef DMA_GNT_TIMEOUT_EN
    check("gnt_timeout", 32'(gnt_timeout), 32'(m_phase == M_BACK));
`endif
  end

  // ---------------- transaction log ----------------
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_q[$];

  always @(negedge clk) begin
    if (dma_mem_wr === 1'b1) begin
      wr_addr_q.push_back(dma_addr);
      wr_data_q.push_back(dma_data);
      wr_cyc_q.push_back(cyc);
      $display("write cycle %0d addr=%h data=%h", cyc, dma_addr, dma_data);
    end
    if (done === 1'b1) begin
      done_q.push_back(cyc);
      $display("done  cycle %0d", cyc);
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_q.delete();
  endtask

  // All stimulus tasks are entered and left just after a falling edge
  task automatic do_reset();
    io_valid = 1'b0; bus_gnt = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic push_word(input logic [31:0] d, output int acc_cyc);
    bit r;
    int k;
    io_valid = 1'b1;
    io_data = d;
    k = 0;
    forever begin
      r = io_ready;
      @(negedge clk);
      k++;
      if (r) break;
      if (k > 300) begin
        check("push_timeout", 32'(k), 32'd0);
        break;
      end
    end
    io_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    if (k == 200) check("done_timeout", 32'(k), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_first_write();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dma_mem_wr === 1'b1) break;
    end
    if (k == 200) check("write_timeout", 32'(k), 32'd0);
  endtask

  initial begin
    int acc;
    int acc_list[9];

    @(negedge clk);
    do_reset();
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_io_ready",   32'(io_ready),   32'd1);
    check("rst_bus_req",    32'(bus_req),    32'd0);
    check("rst_dma_mem_wr", 32'(dma_mem_wr), 32'd0);

    // Basic 4-word burst with grant held
    burst_len = 4'd4; base_addr = 32'h100; bus_gnt = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), acc);
    wait_done();
    check("basic_nwr", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check("basic_addr", wr_addr_q[i], 32'h100 + 32'(4 * i));
      check("basic_data", wr_data_q[i], 32'hA0 + 32'(i));
      check("basic_cyc",  32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
    end
    if (wr_cyc_q.size() == 4 && done_q.size() == 1)
      check("basic_done_cyc", 32'(done_q[0]), 32'(wr_cyc_q[3] + 1));
    else
      check("basic_ndone", 32'(done_q.size()), 32'd1);
    check("basic_count_end", 32'(fifo_count), 32'd0);

    // Backpressure: nine words into eight entries with no grant at first
    do_reset();
    burst_len = 4'd8; base_addr = 32'h200;
    fork
      for (int i = 0; i < 9; i++) begin
        push_word(32'hB0 + 32'(i), acc);
        acc_list[i] = acc;
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_full_ready", 32'(io_ready),   32'd0);
        check("bp_full_count", 32'(fifo_count), 32'd8);
        repeat (5) @(negedge clk);
        bus_gnt = 1'b1;
      end
    join
    wait_done();
    check("bp_nwr", 32'(wr_addr_q.size()), 32'd8);
    if (wr_cyc_q.size() == 8) begin
      check("bp_9th_accept", 32'(acc_list[8]), 32'(wr_cyc_q[0] + 1));
      check("bp_last_data", wr_data_q[7], 32'hB7);
    end
    check("bp_left", 32'(fifo_count), 32'd1);

    // Grant dropped for two cycles after the first write
    do_reset();
    burst_len = 4'd3; base_addr = 32'h0;
    for (int i = 0; i < 3; i++) push_word(32'hC0 + 32'(i), acc);
    bus_gnt = 1'b1;
    wait_first_write();
    bus_gnt = 1'b0;
    repeat (2) @(negedge clk);
    bus_gnt = 1'b1;
    wait_done();
    check("gd_nwr", 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() == 3) begin
      check("gd_addr1", wr_addr_q[1], 32'h4);
      check("gd_addr2", wr_addr_q[2], 32'h8);
      check("gd_data2", wr_data_q[2], 32'hC2);
      check("gd_gap",   32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd3);
      check("gd_back",  32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd1);
    end

    // burst_len 0 behaves as a single word
    do_reset();
    burst_len = 4'd0; base_addr = 32'h40; bus_gnt = 1'b1;
    push_word(32'h55, acc);
    wait_done();
    check("len0_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_cyc_q.size() == 1 && done_q.size() == 1)
      check("len0_done", 32'(done_q[0]), 32'(wr_cyc_q[0] + 1));

    // Address wrap across the top of the space
    do_reset();
    burst_len = 4'd2; base_addr = 32'hFFFF_FFFC; bus_gnt = 1'b1;
    push_word(32'h11, acc);
    push_word(32'h22, acc);
    wait_done();
    check("wrap_nwr", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("wrap_addr0", wr_addr_q[0], 32'hFFFF_FFFC);
      check("wrap_addr1", wr_addr_q[1], 32'h0);
    end

    // Asynchronous reset during the transfer
    do_reset();
    burst_len = 4'd4; base_addr = 32'h300;
    for (int i = 0; i < 4; i++) push_word(32'hD0 + 32'(i), acc);
    bus_gnt = 1'b1;
    wait_first_write();
    check("mid_wr_before", 32'(dma_mem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_wr",    32'(dma_mem_wr), 32'd0);
    check("mid_req",   32'(bus_req),    32'd0);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_addr",  dma_addr,        32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    repeat (12) @(negedge clk);
    check("mid_no_done", 32'(done_q.size()), 32'd0);
    check("mid_no_wr",   32'(wr_addr_q.size()), 32'd0);

`ifdef DMA_GNT_TIMEOUT_EN
    // Grant never arrives: request backs off every TMO cycles
    do_reset();
    burst_len = 4'd4; base_addr = 32'h500;
    for (int i = 0; i < 4; i++) push_word(32'hE0 + 32'(i), acc);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 3 * (TMO + 1); i++) begin
        @(negedge clk);
        if (gnt_timeout === 1'b1) pulses++;
      end
      check("tmo_pulses", 32'(pulses), 32'd3);
      check("tmo_count",  32'(fifo_count), 32'd4);
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      io_valid = ($urandom_range(0, 2) != 0);
      io_data = $urandom;
      bus_gnt = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) burst_len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0)
        base_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      @(negedge clk);
    end
    io_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
